// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, default transfer width and bus mode.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        TRANSFER,
        HOLD,
        DONE
    } spi_state_t;

    localparam int SPI_DATA_W = 8;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period counter, leading/trailing edge ticks and registered sclk.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic half_tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             sclk_reg;

    // Ticks fire in the last cycle of a half-period, so the edge they announce
    // lands on the same clk edge that acts on them.
    assign half_tick = en && (cnt_reg == CNT_LAST);
    assign rise_tick = half_tick && toggle_en && (sclk_reg == CPOL);
    assign fall_tick = half_tick && toggle_en && (sclk_reg != CPOL);
    assign sclk      = sclk_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            sclk_reg <= CPOL;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= CPOL;
        end else begin
            cnt_reg <= half_tick ? '0 : cnt_reg + 1'b1;
            if (rise_tick || fall_tick) begin
                sclk_reg <= ~sclk_reg;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0, MSB first.
// Optional SPI_MASTER_LOOPBACK_EN: receive shifter samples the outgoing MOSI instead of MISO.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              select,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_t state_reg, state_next;

    logic [DATA_W-1:0] tx_shift_reg;
    logic [DATA_W-1:0] rx_shift_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              tail_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              select_reg;

    logic gen_en;
    logic gen_toggle;
    logic half_tick;
    logic rise_tick;
    logic fall_tick;
    logic sample_tick;
    logic shift_tick;
    logic last_bit;
    logic rx_bit;

    assign gen_en     = (state_reg == SETUP) || (state_reg == TRANSFER) || (state_reg == HOLD);
    assign gen_toggle = (state_reg == TRANSFER);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (gen_en),
        .toggle_en(gen_toggle),
        .half_tick(half_tick),
        .rise_tick(rise_tick),
        .fall_tick(fall_tick),
        .sclk     (sclk)
    );

    assign sample_tick = CPHA ? fall_tick : rise_tick;
    assign shift_tick  = CPHA ? rise_tick : fall_tick;
    assign last_bit    = (bit_cnt_reg == BIT_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = tx_shift_reg[DATA_W-1];
`else
    assign rx_bit = MISO;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = SETUP;
            SETUP:    if (half_tick) state_next = TRANSFER;
            TRANSFER: if (shift_tick && last_bit) state_next = HOLD;
            HOLD:     if (tail_reg) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // MOSI is the top bit of the transmit shifter, so it only moves on the
    // accepting edge and on trailing sclk edges, and reads 0 whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            bit_cnt_reg  <= '0;
            tail_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            select_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    bit_cnt_reg <= '0;
                    tail_reg    <= 1'b0;
                    if (start) begin
                        tx_shift_reg <= tx_data;
                        rx_shift_reg <= '0;
                        busy_reg     <= 1'b1;
                        select_reg   <= 1'b1;
                    end
                end
                TRANSFER: begin
                    if (sample_tick) begin
                        rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], rx_bit};
                    end
                    if (shift_tick && !last_bit) begin
                        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                        tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
                    end
                end
                HOLD: begin
                    // One extra cycle after the low half-period lets select trail sclk.
                    if (half_tick) begin
                        tail_reg <= 1'b1;
                    end
                    if (tail_reg) begin
                        tx_shift_reg <= '0;
                        rx_data_reg  <= rx_shift_reg;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        select_reg   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;
    assign select  = select_reg;
    assign MOSI    = tx_shift_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: CLK_DIV=2 and CLK_DIV=1 instances, each with a mode-0 slave model and scoreboard.
module tb_spi_master;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         acc;
    } exp_t;

    localparam int A_LAT = 18 * 2 + 1;
    localparam int B_LAT = 18 * 1 + 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_start, a_busy, a_done, a_sclk, a_select, a_mosi, a_miso;
    logic [7:0] a_tx, a_rx_data, a_slv_tx, a_slv_sh, a_cap;
    logic       b_start, b_busy, b_done, b_sclk, b_select, b_mosi, b_miso;
    logic [7:0] b_tx, b_rx_data, b_slv_tx, b_slv_sh, b_cap;

    int   a_done_cnt = 0, a_last_done = 0, a_rises = 0;
    int   b_done_cnt = 0, b_last_done = 0, b_rises = 0;
    bit   a_sel_bad = 0, a_idle_sclk_bad = 0, a_period_bad = 0;
    bit   b_sel_bad = 0, b_idle_sclk_bad = 0, b_period_bad = 0;
    time  a_last_rise, b_last_rise;
    exp_t a_q[$], b_q[$];
    exp_t a_e, b_e;

    spi_master #(.CLK_DIV(2), .DATA_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx),
        .busy(a_busy), .done(a_done), .rx_data(a_rx_data),
        .sclk(a_sclk), .select(a_select), .MOSI(a_mosi), .MISO(a_miso)
    );

    spi_master #(.CLK_DIV(1), .DATA_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx),
        .busy(b_busy), .done(b_done), .rx_data(b_rx_data),
        .sclk(b_sclk), .select(b_select), .MOSI(b_mosi), .MISO(b_miso)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] slv);
`ifdef SPI_MASTER_LOOPBACK_EN
        return tx;
`else
        return slv;
`endif
    endfunction

    // Mode-0 slave models: load on select rise, capture MOSI on sclk rise, shift MISO on sclk fall.
    always @(posedge a_select) begin
        a_slv_sh = a_slv_tx; a_miso = a_slv_tx[7];
        a_cap = 8'h00; a_rises = 0; a_period_bad = 0;
    end
    always @(posedge a_sclk) if (a_select) begin
        a_cap = {a_cap[6:0], a_mosi};
        if (a_rises != 0 && ($time - a_last_rise) != 40) a_period_bad = 1;
        a_rises++; a_last_rise = $time;
    end
    always @(negedge a_sclk) if (a_select) begin
        a_slv_sh = a_slv_sh << 1; a_miso = a_slv_sh[7];
    end

    always @(posedge b_select) begin
        b_slv_sh = b_slv_tx; b_miso = b_slv_tx[7];
        b_cap = 8'h00; b_rises = 0; b_period_bad = 0;
    end
    always @(posedge b_sclk) if (b_select) begin
        b_cap = {b_cap[6:0], b_mosi};
        if (b_rises != 0 && ($time - b_last_rise) != 20) b_period_bad = 1;
        b_rises++; b_last_rise = $time;
    end
    always @(negedge b_sclk) if (b_select) begin
        b_slv_sh = b_slv_sh << 1; b_miso = b_slv_sh[7];
    end

    // Scoreboard monitors: every done pops one expectation.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (a_busy === 1'b0 && a_sclk !== 1'b0) a_idle_sclk_bad = 1;
            if (a_busy === 1'b1 && a_select !== 1'b1) a_sel_bad = 1;
            if (a_done === 1'b1) begin
                a_done_cnt++; a_last_done = cyc;
                chk("a_done_expected", 32'(a_q.size() != 0), 1);
                if (a_q.size() != 0) begin
                    a_e = a_q.pop_front();
                    chk("a_rx_data", a_rx_data, a_e.rx);
                    chk("a_done_latency", cyc - a_e.acc, A_LAT);
                    chk("a_mosi_bits", a_cap, a_e.tx);
                    chk("a_sclk_rises", a_rises, 8);
                    chk("a_sclk_period", a_period_bad, 0);
                    chk("a_select_window", a_sel_bad, 0);
                    chk("a_busy_select_at_done", {a_busy, a_select}, 0);
                end
                a_sel_bad = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (b_busy === 1'b0 && b_sclk !== 1'b0) b_idle_sclk_bad = 1;
            if (b_busy === 1'b1 && b_select !== 1'b1) b_sel_bad = 1;
            if (b_done === 1'b1) begin
                b_done_cnt++; b_last_done = cyc;
                chk("b_done_expected", 32'(b_q.size() != 0), 1);
                if (b_q.size() != 0) begin
                    b_e = b_q.pop_front();
                    chk("b_rx_data", b_rx_data, b_e.rx);
                    chk("b_done_latency", cyc - b_e.acc, B_LAT);
                    chk("b_mosi_bits", b_cap, b_e.tx);
                    chk("b_sclk_rises", b_rises, 8);
                    chk("b_sclk_period", b_period_bad, 0);
                    chk("b_select_window", b_sel_bad, 0);
                    chk("b_busy_select_at_done", {b_busy, b_select}, 0);
                end
                b_sel_bad = 0;
            end
        end
    end

    task automatic start_a(input logic [7:0] tx, input logic [7:0] slv);
        @(negedge clk);
        a_slv_tx = slv; a_tx = tx; a_start = 1'b1;
        a_q.push_back('{rx: exp_rx(tx, slv), tx: tx, acc: cyc + 1});
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_busy_on_accept", a_busy, 1);
        chk("a_select_on_accept", a_select, 1);
        chk("a_mosi_msb_on_accept", a_mosi, tx[7]);
    endtask

    task automatic start_b(input logic [7:0] tx, input logic [7:0] slv);
        @(negedge clk);
        b_slv_tx = slv; b_tx = tx; b_start = 1'b1;
        b_q.push_back('{rx: exp_rx(tx, slv), tx: tx, acc: cyc + 1});
        @(posedge clk); #1;
        b_start = 1'b0;
        chk("b_busy_on_accept", b_busy, 1);
        chk("b_mosi_msb_on_accept", b_mosi, tx[7]);
    endtask

    task automatic wait_a(input int target, input string tag);
        int n;
        n = 0;
        while (a_done_cnt < target && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk(tag, a_done_cnt, target);
    endtask

    task automatic wait_b(input int target, input string tag);
        int n;
        n = 0;
        while (b_done_cnt < target && n < 200) begin
            @(posedge clk); #2; n++;
        end
        chk(tag, b_done_cnt, target);
    endtask

    initial begin
        int first_done;
        int acc1;
        rst = 1'b1;
        a_start = 1'b0; a_tx = 8'h00; a_slv_tx = 8'h00; a_miso = 1'b0;
        b_start = 1'b0; b_tx = 8'h00; b_slv_tx = 8'h00; b_miso = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("a_reset_outputs", {a_busy, a_done, a_sclk, a_select, a_mosi}, 0);
        chk("a_reset_rx_data", a_rx_data, 0);
        chk("b_reset_outputs", {b_busy, b_done, b_sclk, b_select, b_mosi}, 0);
        chk("b_reset_rx_data", b_rx_data, 0);

        // Basic exchange: C4 out, A5 back.
        start_a(8'hC4, 8'hA5);
        wait_a(1, "a_basic_done_timeout");

        // Second start pulsed mid-transfer must be ignored.
        start_a(8'h3B, 8'h6D);
        repeat (9) @(negedge clk);
        a_tx = 8'hEE; a_slv_tx = 8'h11; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a(2, "a_ignored_start_done_timeout");
        repeat (50) @(negedge clk);
        chk("a_no_queued_start", a_done_cnt, 2);
        chk("a_idle_after_ignore", a_busy, 0);

        // Asynchronous reset during bit 4 aborts without done.
        start_a(8'hFF, 8'h0F);
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("a_abort_outputs", {a_busy, a_done, a_sclk, a_select, a_mosi}, 0);
        chk("a_abort_rx_data", a_rx_data, 0);
        a_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("a_no_done_after_abort", a_done_cnt, 2);
        start_a(8'h3C, 8'hE7);
        wait_a(3, "a_post_abort_done_timeout");

        // start held high: back-to-back transfers, second latches 80.
        @(negedge clk);
        a_slv_tx = 8'hC3; a_tx = 8'h01; a_start = 1'b1;
        a_q.push_back('{rx: exp_rx(8'h01, 8'hC3), tx: 8'h01, acc: cyc + 1});
        @(posedge clk); #1;
        acc1 = cyc;
        a_tx = 8'h80; a_slv_tx = 8'h5E;
        a_q.push_back('{rx: exp_rx(8'h80, 8'h5E), tx: 8'h80, acc: acc1 + A_LAT + 2});
        wait_a(4, "a_held_first_done_timeout");
        first_done = a_last_done;
        @(negedge clk);
        @(posedge clk); #1;
        a_start = 1'b0;
        chk("a_held_retrigger_busy", a_busy, 1);
        wait_a(5, "a_held_second_done_timeout");
        chk("a_done_spacing", a_last_done - first_done, 39);
        chk("a_sclk_idle_low", a_idle_sclk_bad, 0);

        // MISO tied low; with loopback the byte comes back unchanged.
        start_a(8'h96, 8'h00);
        wait_a(6, "a_zero_miso_done_timeout");

        // CLK_DIV=1 instance.
        start_b(8'h5A, 8'h00);
        wait_b(1, "b_first_done_timeout");
        start_b(8'hC4, 8'hA5);
        wait_b(2, "b_second_done_timeout");
        chk("b_sclk_idle_low", b_idle_sclk_bad, 0);
        chk("a_scoreboard_empty", a_q.size(), 0);
        chk("b_scoreboard_empty", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-wide SPI master that drives `sclk`, `select` and `MOSI` toward the existing SPI slave and captures `MISO` from it. It turns a single-cycle `start` request into one full 8-bit exchange: it shifts out `tx_data` MSB first, shifts in `rx_data`, then pulses `done`. It sits between the system-side controller and the slave on the same SPI bus. All logic runs from one system clock, and `sclk` is derived from it.

## Interface
- `CLK_DIV`, default 2: `sclk` half-period in `clk` cycles; legal range is ≥1.
- `DATA_W`, default 8: transfer width in bits.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  transfer request; sampled only in IDLE.
- `tx_data`  input  DATA_W  byte to send; latched on the accepting edge.
- `busy`  output  1  high from the accepting edge until `done` is issued.
- `done`  output  1  one-cycle pulse when `rx_data` is valid.
- `rx_data`  output  DATA_W  received byte; holds its value until the next `done`.
- `sclk`  output  1  SPI clock; idles low.
- `select`  output  1  slave select, active-high.
- `MOSI`  output  1  serial data to the slave.
- `MISO`  input  1  serial data from the slave.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
  - `MOSI` changes only while `sclk` is low.
  - Master samples `MISO` and the slave samples `MOSI` on `sclk` rising.
- States and transitions:
  - IDLE → SETUP when `start`=1. On this edge `tx_data` is latched into the shift register, `busy`=1, `select`=1, and `MOSI`=bit 7.
  - SETUP holds for CLK_DIV cycles with `sclk` low, then → TRANSFER.
  - TRANSFER runs 2*DATA_W half-periods of CLK_DIV cycles each.
    - Each rising `sclk` shifts `MISO` into the receive register LSB.
    - Each falling `sclk` except the last shifts the next bit onto `MOSI`.
    - After the last falling edge → HOLD.
  - HOLD holds for CLK_DIV cycles with `sclk` low and `select` still 1, then → DONE.
  - DONE lasts 1 cycle: `select`=0, `done`=1, `rx_data` updated, `busy`=0. Then → IDLE.
- `start` is ignored while `busy`=1; it is not queued.
- `start` held high re-triggers on the first IDLE cycle after DONE.
- `tx_data` changes after acceptance have no effect on the current transfer.
- A half-period counter counts 0..CLK_DIV-1 and wraps to 0. A bit counter counts 0..DATA_W-1. Both clear in IDLE.
- Reset values: `busy`=0, `done`=0, `rx_data`=0, `sclk`=0, `select`=0, `MOSI`=0, state=IDLE.
- Reset mid-transfer aborts immediately and asynchronously to the reset values. No `done` is issued.

## Timing
- `done` asserts exactly 18*CLK_DIV+1 cycles after the accepting edge when DATA_W=8; in general (2*DATA_W+2)*CLK_DIV+1.
- The first `sclk` rise occurs CLK_DIV+CLK_DIV cycles after acceptance: SETUP, then the first low half-period.
- Minimum spacing between back-to-back transfers: `done` cycle + 1 IDLE cycle.
- `MISO` is sampled on the `clk` edge that drives `sclk` high. No synchronizer is used; the slave updates `MISO` on falling `sclk`.

## Configuration
- `SPI_MASTER_LOOPBACK_EN`
  - Defined: the receive shifter samples the internal `MOSI` instead of the `MISO` port, so `rx_data` equals the transmitted byte. The `MISO` port remains present but unused.
  - Undefined: normal `MISO` sampling.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum `spi_state_t` (IDLE, SETUP, TRANSFER, HOLD, DONE);
  - `SPI_DATA_W` = 8;
  - the mode constants CPOL=0, CPHA=0.
- One sub-module, `spi_clk_gen`:
  - counts CLK_DIV while enabled;
  - emits one-cycle `rise_tick` and `fall_tick` pulses;
  - drives registered `sclk`.
- The FSM and shift registers live in `spi_master`.

## Test plan
- CLK_DIV=2, `tx_data`=8'hC4, slave model returns 8'hA5:
  - `MOSI` on successive rising `sclk` edges is 1,1,0,0,0,1,0,0;
  - `rx_data`=8'hA5;
  - `done` arrives 37 cycles after acceptance;
  - `select` is high for the whole window.
- Pulse `start` again at cycle 10 of a transfer: it is ignored; exactly one `done`, and `rx_data` comes from the first transfer only.
- Assert `rst` during bit 4 of a transfer with `tx_data`=8'hFF:
  - all outputs return to reset values within the same cycle;
  - no `done` is issued;
  - a subsequent transfer of 8'h3C completes correctly.
- Hold `start` high with `tx_data` 8'h01 then 8'h80:
  - two transfers run, with `done` pulses 39 cycles apart at CLK_DIV=2;
  - `sclk` stays low between them.
- CLK_DIV=1, `tx_data`=8'h5A, slave returns 8'h00: 8 `sclk` periods of 2 cycles each, `done` at cycle 19, `rx_data`=8'h00.
- Define `SPI_MASTER_LOOPBACK_EN`, `tx_data`=8'h96, `MISO` tied to 0: `rx_data`=8'h96.
